decode_issue_queue: RTL and testbench



---
 rtl/decode_issue_queue.sv | 105 ++++++++++
 tb/tb_decode_issue_queue.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_queue.sv
// rtl/decode_issue_queue.sv - in-order decode-to-issue queue with single-outstanding-branch hold
//
// Purpose: circular buffer of DEPTH decoded entries between decode and issue.
// After a control-flow entry is handed to issue, presentation stops until
// resolve_branch_i arrives; pushes are still accepted in the meantime.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   flush_i                 drop all entries, clear branch wait
//   decoded_instr_*         decoder side (payload, valid, ctrl-flow flag, ack)
//   issue_instr_*           issue side (head payload, valid, ctrl-flow flag, ack)
//   resolve_branch_i        outstanding control-flow instruction resolved
//   occupancy_o             registered entry count
//   branch_pending_o        high while waiting for a resolve
module decode_issue_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 128
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [DATA_WIDTH-1:0]      decoded_instr_i,
  input  logic                       decoded_instr_valid_i,
  input  logic                       is_ctrl_flow_i,
  output logic                       decoded_instr_ack_o,
  output logic [DATA_WIDTH-1:0]      issue_instr_o,
  output logic                       issue_instr_valid_o,
  output logic                       issue_is_ctrl_flow_o,
  input  logic                       issue_instr_ack_i,
  input  logic                       resolve_branch_i,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic                       branch_pending_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [0:0] ST_RUN          = 1'b0;
  localparam logic [0:0] ST_WAIT_RESOLVE = 1'b1;

  logic [DATA_WIDTH-1:0] payload_mem [DEPTH];
  logic [DEPTH-1:0]      ctrl_mem;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [0:0]            state;

  logic push;
  logic pop;
  logic head_ctrl;

  assign head_ctrl = ctrl_mem[rd_ptr];

  // No pass-through when full: a same-cycle pop does not free a slot for the push.
  assign decoded_instr_ack_o = !rst_i && !flush_i && (count < CNT_W'(DEPTH));
  assign issue_instr_valid_o = !rst_i && !flush_i && (count != '0) && (state == ST_RUN);

  assign push = decoded_instr_valid_i && decoded_instr_ack_o;
  assign pop  = issue_instr_valid_o && issue_instr_ack_i;

  assign issue_instr_o        = payload_mem[rd_ptr];
  assign issue_is_ctrl_flow_o = head_ctrl;

  assign occupancy_o      = rst_i ? '0 : count;
  assign branch_pending_o = !rst_i && (state == ST_WAIT_RESOLVE);

  // Payload storage carries no reset; only valid slots are ever presented.
  always_ff @(posedge clk_i) begin
    if (push) begin
      payload_mem[wr_ptr] <= decoded_instr_i;
      ctrl_mem[wr_ptr]    <= is_ctrl_flow_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A resolve seen in the same cycle as a control-flow pop belongs to an
  // older branch, so RUN only looks at the pop.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:          if (pop && head_ctrl) state <= ST_WAIT_RESOLVE;
        ST_WAIT_RESOLVE: if (resolve_branch_i) state <= ST_RUN;
        default:         state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_issue_queue.sv
// tb/tb_decode_issue_queue.sv - randomized and directed bench for decode_issue_queue against a queue model
module tb_decode_issue_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 128;

  logic          clk = 1'b0;
  logic          rst, flush, din_valid, din_ctrl, iss_ack, resolve;
  logic [DW-1:0] din;
  logic          din_ack, iss_valid, iss_ctrl, bpend;
  logic [DW-1:0] iss_data;
  logic [2:0]    occ;

  decode_issue_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .flush_i               (flush),
    .decoded_instr_i       (din),
    .decoded_instr_valid_i (din_valid),
    .is_ctrl_flow_i        (din_ctrl),
    .decoded_instr_ack_o   (din_ack),
    .issue_instr_o         (iss_data),
    .issue_instr_valid_o   (iss_valid),
    .issue_is_ctrl_flow_o  (iss_ctrl),
    .issue_instr_ack_i     (iss_ack),
    .resolve_branch_i      (resolve),
    .occupancy_o           (occ),
    .branch_pending_o      (bpend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          ctrl;
  } entry_t;

  entry_t        model_q[$];
  bit            model_pending;
  logic [DW-1:0] popped[$];
  bit            did_push;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs at negedge against the model, advance model at posedge.
  task automatic cycle(input bit r, input bit f, input bit v, input logic [DW-1:0] d,
                       input bit c, input bit a, input bit res);
    bit     e_ack, e_valid, e_pop;
    entry_t head;
    rst = r; flush = f; din_valid = v; din = d; din_ctrl = c; iss_ack = a; resolve = res;
    e_ack   = !r && !f && (model_q.size() < DEPTH);
    e_valid = !r && !f && (model_q.size() != 0) && !model_pending;
    @(negedge clk);
    check("ack", din_ack, e_ack);
    check("valid", iss_valid, e_valid);
    check("occupancy", occ, r ? 0 : model_q.size());
    check("branch_pending", bpend, !r && model_pending);
    if (e_valid) begin
      check("head_data", iss_data, model_q[0].data);
      check("head_ctrl", iss_ctrl, model_q[0].ctrl);
    end
    e_pop    = e_valid && a;
    did_push = v && e_ack;
    if (e_pop) popped.push_back(iss_data);
    @(posedge clk);
    if (r || f) begin
      model_q.delete();
      model_pending = 0;
      did_push = 0;
    end else begin
      if (e_pop) begin
        head = model_q.pop_front();
        if (head.ctrl) model_pending = 1;
      end else if (model_pending && res) begin
        model_pending = 0;
      end
      if (did_push) model_q.push_back('{data: d, ctrl: c});
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, 0, 0, 0);
  endtask

  task automatic push(input logic [DW-1:0] d, input bit c);
    cycle(0, 0, 1, d, c, 0, 0);
  endtask

  task automatic drain();
    int guard = 0;
    while ((model_q.size() != 0 || model_pending) && guard < 40) begin
      cycle(0, 0, 0, '0, 0, 1, model_pending);
      guard++;
    end
    check("drain_done", model_q.size(), 0);
  endtask

  initial begin
    rst = 1; flush = 0; din_valid = 0; din = '0; din_ctrl = 0; iss_ack = 0; resolve = 0;
    model_pending = 0;
    cycle(1, 0, 1, 128'h55, 0, 1, 0);
    cycle(1, 0, 0, '0, 0, 0, 0);

    // A, B, C with issue held off
    push(128'hA, 0); push(128'hB, 0); push(128'hC, 0);
    check("occ_after_abc", occ, 3);
    idle(1);

    // Fill and full behaviour: pop with push attempted while full is refused
    push(128'hD, 0);
    check("occ_full", occ, 4);
    cycle(0, 0, 1, 128'hE, 0, 0, 0);
    cycle(0, 0, 1, 128'hE, 0, 1, 0);
    check("occ_after_pop_full", occ, 3);
    push(128'hE, 0);
    check("occ_refill", occ, 4);
    drain();

    // Branch hold, resolve three cycles later
    push(128'h1111, 1); push(128'h2222, 0);
    cycle(0, 0, 0, '0, 0, 1, 0);
    check("bp_after_j", bpend, 1);
    check("occ_after_j", occ, 1);
    idle(2);
    cycle(0, 0, 0, '0, 0, 0, 1);
    idle(1);
    drain();

    // Resolve in the same cycle as the control-flow pop is ignored
    push(128'h3333, 1); push(128'h4444, 0);
    cycle(0, 0, 0, '0, 0, 1, 1);
    check("bp_same_cycle_resolve", bpend, 1);
    cycle(0, 0, 0, '0, 0, 1, 0);
    cycle(0, 0, 0, '0, 0, 0, 1);
    drain();

    // Flush while waiting with three entries queued
    push(128'h5555, 1); push(128'h6, 0); push(128'h7, 0); push(128'h8, 0);
    cycle(0, 0, 0, '0, 0, 1, 0);
    check("occ_before_flush", occ, 3);
    cycle(0, 1, 1, 128'h9, 0, 1, 1);
    check("occ_after_flush", occ, 0);
    check("bp_after_flush", bpend, 0);
    idle(1);

    // Wrap-around ordering: 0..9 through the queue with random issue ack
    begin
      int nxt = 0;
      int guard = 0;
      popped.delete();
      while ((nxt < 10 || model_q.size() != 0) && guard < 200) begin
        cycle(0, 0, nxt < 10, DW'(nxt), 0, $urandom_range(0, 1) == 1, 0);
        if (did_push) nxt++;
        guard++;
      end
      check("wrap_count", popped.size(), 10);
      for (int i = 0; i < popped.size() && i < 10; i++) check("wrap_order", popped[i], DW'(i));
    end

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 4, $urandom_range(0, 1) == 1,
            {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
